pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//   Owns the program counter; produces PC_plus_one and consumes the branch target that ALU_1
//   computes from it. Fetches instructions over a req/ack handshake to instruction memory and
//   delivers them to decode with stall and branch-redirect (squash) support.
// PARAMETERS
//   N         16     datapath/address width (bits)
//   RESET_PC  0      PC value loaded on reset
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous, active-low reset
//   branch_taken   in   1   redirect request from branch resolution (single-cycle pulse or level)
//   branch_target  in   N   redirect address (driven from ALU_1_out)
//   stall          in   1   decode cannot accept the delivered instruction this cycle
//   imem_ack       in   1   imem completes the transfer this cycle; imem_rdata is valid
//   imem_rdata     in   N   instruction word from imem
//   imem_req       out  1   fetch request, combinational = (state==S_REQ)
//   imem_addr      out  N   fetch address = PC
//   instr_valid    out  1   instr_out holds a valid instruction (registered)
//   instr_out      out  N   delivered instruction (registered)
//   PC             out  N   current PC register
//   PC_plus_one    out  N   PC+1, combinational, mod 2^N (feeds ALU_1)
// BEHAVIOUR
//   Reset (async, rst_n=0): PC=RESET_PC, state=S_BOOT, instr_valid=0, instr_out=0,
//     redir_pend=0, redir_tgt=0; imem_req=0. Any outstanding request is abandoned.
//   States: S_BOOT -> S_REQ unconditionally on the first clock after reset release.
//   S_REQ: imem_req=1; imem_addr=PC, stable until imem_ack.
//     ack=0, branch_taken=1: redir_pend<=1, redir_tgt<=branch_target (a later branch overwrites).
//     ack=1, branch_taken=1: drop rdata; PC<=branch_target; clear pend; stay S_REQ.
//     ack=1, redir_pend=1, branch_taken=0: drop rdata; PC<=redir_tgt; clear pend; stay S_REQ.
//     ack=1, no redirect: instr_out<=imem_rdata, instr_valid<=1, -> S_DELIV; PC unchanged.
//   S_DELIV: imem_req=0, instr_valid=1, instr_out held.
//     branch_taken=1 (priority over stall): squash; instr_valid<=0; PC<=branch_target; -> S_REQ.
//     stall=1: hold everything.
//     else: instruction consumed; instr_valid<=0; PC<=PC_plus_one; -> S_REQ.
//   Latency: req to instr_valid = ack cycle + 1. Best case 2 clocks per instruction.
//   Arithmetic: PC increment wraps; 16'hFFFF+1 -> 16'h0000, with no flag.
//   Priority: branch_taken > redir_pend > stall.
//   branch_taken in S_BOOT is ignored.
// STRUCTURE
//   Shared package risc_pkg: N, RESET_PC, fetch_state_t {S_BOOT,S_REQ,S_DELIV} encoding.
//   One sub-module pc_redirect_reg: redir_pend/redir_tgt capture and clear, async reset.
//   Everything else lives in this module.
// TESTING
//   1. Reset, imem acks every request, RESET_PC=0, rdata=addr^16'hA5A5:
//      imem_addr 0,1,2,3; instr_out A5A5,A5A4,A5A7,A5A6 in order.
//   2. In S_DELIV with PC=5: stall high 3 cycles -> instr_valid held 3 cycles,
//      PC stays 5, imem_req=0; after release PC=6.
//   3. In S_DELIV with PC=7: branch_taken with target 16'h0040 and stall=1 ->
//      instr_valid 0 next cycle, imem_addr=0040.
//   4. S_REQ at PC=8, ack delayed 3 cycles, branch_taken to 0x0100 in wait cycle 1:
//      imem_addr stays 8 until ack, rdata is dropped, next imem_addr=0100.
//      A second branch to 0x0200 in wait cycle 2 -> next imem_addr=0200.
//   5. PC=16'hFFFF, instruction consumed -> PC=16'h0000, PC_plus_one=16'h0001.
//   6. rst_n low mid-wait (ack outstanding) -> same cycle: imem_req=0, instr_valid=0,
//      PC=RESET_PC; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared fetch-side definitions: datapath width, reset PC and fetch FSM encoding.
package risc_pkg;
  localparam int          N        = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_DELIV = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_redirect_reg.sv
// Holds a branch redirect that arrived while an imem request was still outstanding.
module pc_redirect_reg #(
  parameter int N = risc_pkg::N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_capture,
  input  logic         i_clear,
  input  logic [N-1:0] i_target,
  output logic         o_pend,
  output logic [N-1:0] o_tgt
);
  logic         r_pend;
  logic [N-1:0] r_tgt;

  // A later capture simply overwrites the held target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_tgt  <= '0;
    end else if (i_capture) begin
      r_pend <= 1'b1;
      r_tgt  <= i_target;
    end else if (i_clear) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_tgt  = r_tgt;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer with stall and branch squash.
module pc_fetch_sequencer
  import risc_pkg::*;
#(
  parameter int          N        = risc_pkg::N,
  parameter logic [N-1:0] RESET_PC = risc_pkg::RESET_PC[N-1:0]
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         stall,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  output logic         instr_valid,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] PC,
  output logic [N-1:0] PC_plus_one
);
  fetch_state_t r_state;
  logic [N-1:0] r_pc;
  logic         r_instr_valid;
  logic [N-1:0] r_instr_out;
  logic         w_redir_pend;
  logic [N-1:0] w_redir_tgt;
  logic         w_capture;
  logic         w_clear;
  logic [N-1:0] w_pc_plus_one;

  assign w_pc_plus_one = r_pc + {{(N-1){1'b0}}, 1'b1};
  assign w_capture     = (r_state == S_REQ) && !imem_ack && branch_taken;
  assign w_clear       = (r_state == S_REQ) && imem_ack;

  pc_redirect_reg #(.N(N)) u_redir (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_capture(w_capture),
    .i_clear  (w_clear),
    .i_target (branch_target),
    .o_pend   (w_redir_pend),
    .o_tgt    (w_redir_tgt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr_out   <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_REQ;
        S_REQ: begin
          // An ack that coincides with, or follows, a redirect drops the fetched word.
          if (imem_ack) begin
            if (branch_taken) begin
              r_pc <= branch_target;
            end else if (w_redir_pend) begin
              r_pc <= w_redir_tgt;
            end else begin
              r_instr_out   <= imem_rdata;
              r_instr_valid <= 1'b1;
              r_state       <= S_DELIV;
            end
          end
        end
        S_DELIV: begin
          if (branch_taken) begin
            r_instr_valid <= 1'b0;
            r_pc          <= branch_target;
            r_state       <= S_REQ;
          end else if (!stall) begin
            r_instr_valid <= 1'b0;
            r_pc          <= w_pc_plus_one;
            r_state       <= S_REQ;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_out   = r_instr_out;
  assign PC          = r_pc;
  assign PC_plus_one = w_pc_plus_one;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; imem returns addr ^ 16'hA5A5.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b1;
  logic [15:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] PC;
  logic [15:0] PC_plus_one;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 16'hA5A5;

  pc_fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr_valid  (instr_valid),
    .instr_out    (instr_out),
    .PC           (PC),
    .PC_plus_one  (PC_plus_one)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_pc", PC, 16'h0000);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_pcp1", PC_plus_one, 16'h0001);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: back-to-back fetches, ack every request
    step();
    chk("t1_req0", 16'(imem_req), 16'h1);
    chk("t1_addr0", imem_addr, 16'h0000);
    step();
    chk("t1_valid0", 16'(instr_valid), 16'h1);
    chk("t1_instr0", instr_out, 16'hA5A5);
    chk("t1_req_deliv", 16'(imem_req), 16'h0);
    step();
    chk("t1_addr1", imem_addr, 16'h0001);
    chk("t1_valid_off", 16'(instr_valid), 16'h0);
    step();
    chk("t1_instr1", instr_out, 16'hA5A4);
    step();
    chk("t1_addr2", imem_addr, 16'h0002);
    step();
    chk("t1_instr2", instr_out, 16'hA5A7);
    step();
    chk("t1_addr3", imem_addr, 16'h0003);
    step();
    chk("t1_instr3", instr_out, 16'hA5A6);

    // Test 2: advance to DELIV at PC=5 then stall three cycles
    step(); step(); step(); step();
    chk("t2_pc5", PC, 16'h0005);
    chk("t2_valid5", 16'(instr_valid), 16'h1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_valid", 16'(instr_valid), 16'h1);
      chk("t2_stall_pc", PC, 16'h0005);
      chk("t2_stall_req", 16'(imem_req), 16'h0);
      chk("t2_stall_instr", instr_out, 16'hA5A0);
    end
    stall = 1'b0;
    step();
    chk("t2_release_pc", PC, 16'h0006);
    chk("t2_release_valid", 16'(instr_valid), 16'h0);

    // Test 3: branch beats stall in DELIV at PC=7
    step(); step(); step();
    chk("t3_pc7", PC, 16'h0007);
    chk("t3_valid7", 16'(instr_valid), 16'h1);
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
    step();
    chk("t3_squash_valid", 16'(instr_valid), 16'h0);
    chk("t3_addr", imem_addr, 16'h0040);
    chk("t3_req", 16'(imem_req), 16'h1);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk("t3_instr40", instr_out, 16'hA5E5);

    // Test 4: redirect captured during a delayed ack
    branch_taken = 1'b1; branch_target = 16'h0008; imem_ack = 1'b0;
    step();
    chk("t4_addr8", imem_addr, 16'h0008);
    branch_target = 16'h0100;
    step();
    branch_taken = 1'b0;
    chk("t4_wait1_addr", imem_addr, 16'h0008);
    step();
    chk("t4_wait2_addr", imem_addr, 16'h0008);
    chk("t4_wait2_req", 16'(imem_req), 16'h1);
    imem_ack = 1'b1;
    step();
    chk("t4_redir_addr", imem_addr, 16'h0100);
    chk("t4_drop_valid", 16'(instr_valid), 16'h0);
    chk("t4_redir_req", 16'(imem_req), 16'h1);
    imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 16'h0180;
    step();
    branch_target = 16'h0200;
    step();
    branch_taken = 1'b0;
    step();
    chk("t4b_wait_addr", imem_addr, 16'h0100);
    imem_ack = 1'b1;
    step();
    chk("t4b_overwrite_addr", imem_addr, 16'h0200);
    chk("t4b_drop_valid", 16'(instr_valid), 16'h0);
    branch_taken = 1'b1; branch_target = 16'h0300;
    step();
    chk("t4c_ack_branch_pc", PC, 16'h0300);
    chk("t4c_ack_branch_valid", 16'(instr_valid), 16'h0);
    branch_taken = 1'b0;

    // Test 5: PC wrap at 16'hFFFF
    step();
    chk("t5_deliv300", instr_out, 16'hA6A5);
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    chk("t5_pc_ffff", PC, 16'hFFFF);
    chk("t5_pcp1_wrap", PC_plus_one, 16'h0000);
    step();
    chk("t5_instr_ffff", instr_out, 16'h5A5A);
    step();
    chk("t5_pc_wrapped", PC, 16'h0000);
    chk("t5_pcp1", PC_plus_one, 16'h0001);

    // Test 6: asynchronous reset while an ack is outstanding
    step();
    step();
    chk("t6_pc1", PC, 16'h0001);
    imem_ack = 1'b0;
    step();
    chk("t6_wait_req", 16'(imem_req), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 16'(imem_req), 16'h0);
    chk("t6_rst_valid", 16'(instr_valid), 16'h0);
    chk("t6_rst_pc", PC, 16'h0000);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    step();
    chk("t6_restart_addr", imem_addr, 16'h0000);
    chk("t6_restart_req", 16'(imem_req), 16'h1);
    step();
    chk("t6_restart_instr", instr_out, 16'hA5A5);
    chk("t6_restart_valid", 16'(instr_valid), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
